// File: rtl/lego_hdr_pkg.sv
// Lego header layout, tracker state encoding and stream beat payload shared by
// the RX sequence tracker and the cumulative-ACK generator.
package lego_hdr_pkg;

  localparam int unsigned DATA_W = 512;
  localparam int unsigned KEEP_W = 64;
  localparam int unsigned USER_W = 64;
  localparam int unsigned APP_W  = 8;
  localparam int unsigned SEQ_W  = 32;
  localparam int unsigned CNT_W  = 16;

  localparam int unsigned APP_ID_LSB = 336;
  localparam int unsigned SEQ_LSB    = 344;
  localparam int unsigned ACK_BIT    = 376;
  localparam int unsigned SYN_BIT    = 377;

  localparam logic [APP_W-1:0] APP_ID0_DEF = 8'h00;
  localparam logic [APP_W-1:0] APP_ID1_DEF = 8'h01;

  typedef enum logic [1:0] {
    HDR  = 2'b00,
    FWD  = 2'b01,
    DROP = 2'b10
  } rx_state_e;

  typedef struct packed {
    logic [APP_W-1:0] app_id;
    logic [SEQ_W-1:0] seq;
    logic             ack;
    logic             syn;
  } lego_hdr_t;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [USER_W-1:0] tuser;
    logic              tlast;
    logic              tdest;
  } axis_beat_t;

endpackage

// File: rtl/rx_seq_tracker_if.sv
// Sysnet RX input stream and tagged downstream stream of the sequence tracker.
interface rx_seq_tracker_if;
  import lego_hdr_pkg::*;

  logic [DATA_W-1:0] rx_tdata;
  logic [KEEP_W-1:0] rx_tkeep;
  logic [USER_W-1:0] rx_tuser;
  logic              rx_tlast;
  logic              rx_tvalid;
  logic              rx_tready;

  logic [DATA_W-1:0] m_tdata;
  logic [KEEP_W-1:0] m_tkeep;
  logic [USER_W-1:0] m_tuser;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tdest;
  logic              m_tready;

  modport slave (
    input  rx_tdata, rx_tkeep, rx_tuser, rx_tlast, rx_tvalid, m_tready,
    output rx_tready, m_tdata, m_tkeep, m_tuser, m_tlast, m_tvalid, m_tdest
  );

  modport master (
    output rx_tdata, rx_tkeep, rx_tuser, rx_tlast, rx_tvalid, m_tready,
    input  rx_tready, m_tdata, m_tkeep, m_tuser, m_tlast, m_tvalid, m_tdest
  );

endinterface

// File: rtl/axis_reg_slice_512.sv
// Single-stage output register for a 512-bit stream beat with destination tag.
module axis_reg_slice_512
  import lego_hdr_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  input  axis_beat_t in_beat,
  output logic       in_ready_c,
  output logic       out_valid,
  output axis_beat_t out_beat,
  input  logic       out_ready
);

  // Ready also gates the upstream while this block is held in reset.
  assign in_ready_c = resetn && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (in_ready_c) begin
      out_valid <= in_valid;
      if (in_valid) out_beat <= in_beat;
    end
  end

endmodule

// File: rtl/rx_seq_tracker.sv
// Per-app receive sequence checker: forwards in-order Lego packets tagged with
// their slot, drops ACK/unknown/out-of-order packets, exports expected seq.
module rx_seq_tracker
  import lego_hdr_pkg::*;
#(
  parameter logic [APP_W-1:0] APP_ID0 = APP_ID0_DEF,
  parameter logic [APP_W-1:0] APP_ID1 = APP_ID1_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  rx_seq_tracker_if.slave  bus,
  output logic [SEQ_W-1:0] seq0_out,
  output logic [SEQ_W-1:0] seq1_out,
  output logic             seq0_valid,
  output logic             seq1_valid,
  output logic [CNT_W-1:0] drop0_cnt,
  output logic [CNT_W-1:0] drop1_cnt
);

  rx_state_e             state;
  logic [1:0][SEQ_W-1:0] exp_q;
  logic [1:0]            valid_q;
  logic [1:0][CNT_W-1:0] drop_q;
  logic                  cur_slot;

  lego_hdr_t  hdr;
  logic       hit0;
  logic       hit1;
  logic       known;
  logic       slot;
  logic       in_order;
  logic       hdr_fwd;
  logic       hdr_ooo;
  logic       beat_acc;
  logic       fwd_beat;
  axis_beat_t in_beat;
  axis_beat_t out_beat;

  // Header decode and accept/drop decision for the current beat.
  always_comb begin
    hdr.app_id = bus.rx_tdata[APP_ID_LSB +: APP_W];
    hdr.seq    = bus.rx_tdata[SEQ_LSB +: SEQ_W];
    hdr.ack    = bus.rx_tdata[ACK_BIT];
    hdr.syn    = bus.rx_tdata[SYN_BIT];

    hit0     = (hdr.app_id == APP_ID0);
    hit1     = (hdr.app_id == APP_ID1);
    known    = hit0 || hit1;
    slot     = !hit0;
    in_order = (hdr.seq == exp_q[slot]);
    hdr_fwd  = known && !hdr.ack && (hdr.syn || in_order);
    hdr_ooo  = known && !hdr.ack && !hdr.syn && !in_order;

    beat_acc = bus.rx_tvalid && bus.rx_tready;
    fwd_beat = beat_acc && (((state == HDR) && hdr_fwd) || (state == FWD));

    in_beat.tdata = bus.rx_tdata;
    in_beat.tkeep = bus.rx_tkeep;
    in_beat.tuser = bus.rx_tuser;
    in_beat.tlast = bus.rx_tlast;
    in_beat.tdest = (state == HDR) ? slot : cur_slot;
  end

  // Packet FSM plus per-slot expected sequence, valid flag and drop counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= HDR;
      exp_q    <= '0;
      valid_q  <= '0;
      drop_q   <= '0;
      cur_slot <= 1'b0;
    end else if (beat_acc) begin
      case (state)
        HDR: begin
          cur_slot <= slot;
          if (hdr_fwd) begin
            exp_q[slot]   <= (hdr.syn ? hdr.seq : exp_q[slot]) + SEQ_W'(1);
            valid_q[slot] <= 1'b1;
          end
          if (hdr_ooo && (drop_q[slot] != '1)) begin
            drop_q[slot] <= drop_q[slot] + CNT_W'(1);
          end
          if (!bus.rx_tlast) state <= hdr_fwd ? FWD : DROP;
        end
        FWD, DROP: begin
          if (bus.rx_tlast) state <= HDR;
        end
        default: state <= HDR;
      endcase
    end
  end

  axis_reg_slice_512 u_out_slice (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (fwd_beat),
    .in_beat    (in_beat),
    .in_ready_c (bus.rx_tready),
    .out_valid  (bus.m_tvalid),
    .out_beat   (out_beat),
    .out_ready  (bus.m_tready)
  );

  assign bus.m_tdata = out_beat.tdata;
  assign bus.m_tkeep = out_beat.tkeep;
  assign bus.m_tuser = out_beat.tuser;
  assign bus.m_tlast = out_beat.tlast;
  assign bus.m_tdest = out_beat.tdest;

  assign seq0_out   = exp_q[0];
  assign seq1_out   = exp_q[1];
  assign seq0_valid = valid_q[0];
  assign seq1_valid = valid_q[1];
  assign drop0_cnt  = drop_q[0];
  assign drop1_cnt  = drop_q[1];

endmodule

// File: tb/tb_rx_seq_tracker.sv
// Bench for rx_seq_tracker: directed scenarios then random packets, scored
// against a packet-level model of the per-app sequence rules.
module tb_rx_seq_tracker;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic [63:0]  u;
    logic         l;
    logic         dest;
  } tb_beat_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  rx_seq_tracker_if bus ();

  logic [31:0] seq0_out, seq1_out;
  logic        seq0_valid, seq1_valid;
  logic [15:0] drop0_cnt, drop1_cnt;

  rx_seq_tracker dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .seq0_out   (seq0_out),
    .seq1_out   (seq1_out),
    .seq0_valid (seq0_valid),
    .seq1_valid (seq1_valid),
    .drop0_cnt  (drop0_cnt),
    .drop1_cnt  (drop1_cnt)
  );

  int checks = 0;
  int errors = 0;
  int fwd_cnt = 0;
  int rdy_mode = 0;

  tb_beat_t    q[$];
  logic [31:0] m_exp [2];
  bit          m_val [2];
  logic [15:0] m_drop[2];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [511:0] mk_hdr(input logic [7:0] app, input logic [31:0] seq,
                                          input bit ack, input bit syn);
    logic [511:0] v;
    v = rnd512();
    v[343:336] = app;
    v[375:344] = seq;
    v[376] = ack;
    v[377] = syn;
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 2; i++) begin
      m_exp[i] = 32'd0;
      m_val[i] = 1'b0;
      m_drop[i] = 16'd0;
    end
  endtask

  // Downstream ready pattern: 0 always ready, 1 toggling, 2 random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: bus.m_tready = 1'b1;
      1: bus.m_tready = (bus.m_tready === 1'b1) ? 1'b0 : 1'b1;
      default: bus.m_tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Output monitor: every handshake must match the next modelled beat.
  always @(negedge clk) begin
    if (!resetn) begin
      chk("rx_tready_in_reset", bus.rx_tready, 1'b0);
    end else begin
      if (bus.m_tready === 1'b1) chk("rx_tready_when_m_ready", bus.rx_tready, 1'b1);
      else if (bus.m_tvalid === 1'b1) chk("rx_tready_backpressure", bus.rx_tready, 1'b0);
      if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_beat", bus.m_tvalid, 1'b0);
        end else begin
          tb_beat_t b;
          b = q.pop_front();
          chk("m_tdata", bus.m_tdata, b.d);
          chk("m_tkeep", bus.m_tkeep, b.k);
          chk("m_tuser", bus.m_tuser, b.u);
          chk("m_tlast", bus.m_tlast, b.l);
          chk("m_tdest", bus.m_tdest, b.dest);
          fwd_cnt++;
        end
      end
    end
  end

  task automatic put_beat(input logic [511:0] d, input logic [63:0] k,
                          input logic [63:0] u, input logic l);
    int n = 0;
    bus.rx_tdata  = d;
    bus.rx_tkeep  = k;
    bus.rx_tuser  = u;
    bus.rx_tlast  = l;
    bus.rx_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.rx_tready === 1'b1) break;
      n++;
      if (n > 200) begin
        errors++;
        $display("FAIL rx_accept_timeout observed=stalled expected=accepted");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "rx beat never accepted");
      end
    end
    @(posedge clk);
    #1;
    bus.rx_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] app, input logic [31:0] seq, input bit ack,
                          input bit syn, input int nb, input int nsend);
    bit acc = 1'b0;
    int slot = (app == 8'h01) ? 1 : 0;
    bit known = (app == 8'h00) || (app == 8'h01);
    tb_beat_t b;
    if (known && !ack) begin
      if (syn || seq == m_exp[slot]) begin
        acc = 1'b1;
        m_exp[slot] = seq + 32'd1;
        m_val[slot] = 1'b1;
      end else if (m_drop[slot] != 16'hFFFF) begin
        m_drop[slot] = m_drop[slot] + 16'd1;
      end
    end
    for (int i = 0; i < nsend; i++) begin
      b.d = (i == 0) ? mk_hdr(app, seq, ack, syn) : rnd512();
      b.k = {$urandom(), $urandom()};
      b.u = {$urandom(), $urandom()};
      b.l = (i == nb - 1);
      b.dest = 1'(slot);
      if (acc) q.push_back(b);
      put_beat(b.d, b.k, b.u, b.l);
    end
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (q.size() != 0 && n < 500);
    #1;
    chk("drain_pending_beats", 32'(q.size()), 32'd0);
  endtask

  task automatic check_state(input string tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, "_seq0_out"}, seq0_out, m_exp[0]);
    chk({tag, "_seq1_out"}, seq1_out, m_exp[1]);
    chk({tag, "_seq0_valid"}, seq0_valid, m_val[0]);
    chk({tag, "_seq1_valid"}, seq1_valid, m_val[1]);
    chk({tag, "_drop0_cnt"}, drop0_cnt, m_drop[0]);
    chk({tag, "_drop1_cnt"}, drop1_cnt, m_drop[1]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int f0;
    resetn = 1'b0;
    bus.rx_tvalid = 1'b0;
    bus.rx_tdata = '0;
    bus.rx_tkeep = '0;
    bus.rx_tuser = '0;
    bus.rx_tlast = 1'b0;
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", bus.m_tvalid, 1'b0);
    chk("rst_m_tlast", bus.m_tlast, 1'b0);
    chk("rst_m_tdest", bus.m_tdest, 1'b0);
    chk("rst_m_tdata", bus.m_tdata, 512'd0);
    chk("rst_m_tkeep", bus.m_tkeep, 64'd0);
    chk("rst_m_tuser", bus.m_tuser, 64'd0);
    chk("rst_seq0_out", seq0_out, 32'd0);
    chk("rst_seq1_valid", seq1_valid, 1'b0);
    chk("rst_drop0_cnt", drop0_cnt, 16'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Slot 0 in-order single-beat packets
    f0 = fwd_cnt;
    for (int i = 0; i < 3; i++) send_pkt(8'h00, 32'(i), 1'b0, 1'b0, 1, 1);
    drain();
    chk("slot0_fwd_count", 32'(fwd_cnt - f0), 32'd3);
    chk("slot0_seq0_is_3", seq0_out, 32'd3);
    check_state("inorder");

    // Slot 1 out of order
    f0 = fwd_cnt;
    send_pkt(8'h01, 32'd5, 1'b0, 1'b0, 1, 1);
    check_state("ooo");
    chk("ooo_fwd_count", 32'(fwd_cnt - f0), 32'd0);
    chk("ooo_drop1_is_1", drop1_cnt, 16'd1);

    // SYN at FFFFFFFF then wrap to 0
    f0 = fwd_cnt;
    send_pkt(8'h01, 32'hFFFF_FFFF, 1'b0, 1'b1, 1, 1);
    send_pkt(8'h01, 32'd0, 1'b0, 1'b0, 1, 1);
    drain();
    chk("syn_fwd_count", 32'(fwd_cnt - f0), 32'd2);
    chk("syn_wrap_seq1_is_1", seq1_out, 32'd1);
    check_state("syn_wrap");

    // Multi-beat with toggling downstream ready
    rdy_mode = 1;
    f0 = fwd_cnt;
    send_pkt(8'h00, 32'd3, 1'b0, 1'b0, 3, 3);
    drain();
    chk("toggle_fwd_count", 32'(fwd_cnt - f0), 32'd3);
    rdy_mode = 0;
    check_state("toggle");

    // ACK and unknown-app packets are silently consumed
    f0 = fwd_cnt;
    send_pkt(8'h00, 32'd4, 1'b1, 1'b0, 2, 2);
    send_pkt(8'h07, 32'd4, 1'b0, 1'b0, 2, 2);
    check_state("ack_unknown");
    chk("ack_unknown_fwd_count", 32'(fwd_cnt - f0), 32'd0);

    // Reset during beat 2 of a forwarded 4-beat packet
    send_pkt(8'h00, 32'd4, 1'b0, 1'b0, 4, 2);
    resetn = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_m_tvalid", bus.m_tvalid, 1'b0);
    chk("midrst_seq0_out", seq0_out, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    f0 = fwd_cnt;
    send_pkt(8'h00, 32'd0, 1'b0, 1'b0, 1, 1);
    drain();
    chk("post_reset_fwd_count", 32'(fwd_cnt - f0), 32'd1);
    check_state("post_reset");

    // Random traffic with random backpressure
    rdy_mode = 2;
    for (int n = 0; n < 48; n++) begin
      logic [7:0]  app;
      logic [31:0] seq;
      int          sl;
      int          r;
      bit          ack;
      bit          syn;
      int          nb;
      r   = $urandom_range(0, 2);
      app = (r == 0) ? 8'h00 : (r == 1) ? 8'h01 : 8'h07;
      sl  = (app == 8'h01) ? 1 : 0;
      ack = ($urandom_range(0, 7) == 0);
      syn = ($urandom_range(0, 7) == 0);
      r   = $urandom_range(0, 3);
      seq = (r <= 1) ? m_exp[sl] : (r == 2) ? m_exp[sl] + 32'd1 : 32'($urandom());
      nb  = $urandom_range(1, 4);
      send_pkt(app, seq, ack, syn, nb, nb);
      if (n % 8 == 7) begin
        drain();
        check_state("random");
      end
    end
    rdy_mode = 0;
    drain();
    check_state("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_seq_tracker.md
# rx_seq_tracker

Receive-side sequence checker between the Sysnet RX stream and the per-app Libnet instances. Parses the Lego header in the first beat of each 512-bit packet and keeps one expected sequence number per app. In-order data packets go downstream tagged with their app ID; out-of-order, ACK and unknown-app packets are dropped. The current expected sequence numbers drive the cumulative-ACK generator's `seq0_in`/`seq0_valid` and `seq1_in`/`seq1_valid` inputs.

## Interface
- `APP_ID0`, 8'h00, app ID mapped to slot 0
- `APP_ID1`, 8'h01, app ID mapped to slot 1
- `clk`  in  1  clock
- `resetn`  in  1  synchronous, active-low reset
- `rx_tdata`  in  512  Sysnet RX data
- `rx_tkeep`  in  64  byte enables, passed through
- `rx_tuser`  in  64  sideband, passed through
- `rx_tlast`  in  1  end of packet
- `rx_tvalid`  in  1  RX beat valid
- `rx_tready`  out  1  RX beat accepted
- `m_tdata`, `m_tkeep`, `m_tuser`, `m_tlast`, `m_tvalid`  out  512/64/64/1/1  registered copy of forwarded beats
- `m_tdest`  out  1  slot of the forwarded packet (0 or 1)
- `m_tready`  in  1  downstream ready
- `seq0_out`, `seq1_out`  out  32  expected sequence number per slot
- `seq0_valid`, `seq1_valid`  out  1  sticky; high after the slot's first accepted packet
- `drop0_cnt`, `drop1_cnt`  out  16  saturating drop counters per slot

## Operation
- Header fields are taken from the first beat, LSB first:
  - MAC dst [47:0], MAC src [95:48], ethtype [111:96]
  - IP words [271:112], UDP [335:272]
  - app_id [343:336], seq [375:344], ACK [376], SYN [377], pad [511:378]
- States:
  - HDR: waiting for the first beat.
  - FWD: forwarding the remaining beats of an accepted packet.
  - DROP: consuming the remaining beats of a rejected packet.
- Decision on an accepted HDR beat:
  - app_id is neither APP_ID0 nor APP_ID1 → drop; no counter changes.
  - ACK=1 → drop; no counter changes. ACKs are handled elsewhere.
  - SYN=1 → accept; expected[slot] <= seq+1.
  - seq == expected[slot] → accept; expected[slot] <= expected+1.
  - Otherwise (out of order) → drop; drop_cnt[slot] += 1, saturating at 16'hFFFF. Expected is unchanged.
- Transitions:
  - Accepted HDR beat with rlast=1 → stay in HDR (single-beat packet).
  - Accepted HDR beat, rlast=0 → FWD if accepted, DROP if dropped.
  - FWD or DROP beat with rlast=1 → HDR.
- Forwarded beats, header beat included, are copied unchanged to the `m_` port. `m_tdest` holds the slot for the whole packet.
- Dropped beats are consumed and never appear on the `m_` port.
- Sequence arithmetic is 32-bit modulo: FFFFFFFF+1 = 0.
- `seqN_out` always equals expected[N]. `seqN_valid` sets on the first accepted packet for slot N and stays high until reset, so a downstream stage that samples only occasionally still sees the latest value.

## Timing
- Reset values: state HDR; expected 0; `seqN_valid` 0; counters 0; `m_tvalid` 0; `m_tlast` 0; `m_tdest` 0; `m_tdata`, `m_tkeep`, `m_tuser` 0.
- `rx_tready` = `!m_tvalid || m_tready`, in every state including DROP, so drops also stall on downstream backpressure.
- `rx_tready` is 0 while `resetn` is low.
- Forward latency is 1 cycle: a beat accepted at edge N is on `m_` after edge N.
- `m_` outputs hold steady while `m_tvalid && !m_tready`.
- The expected-sequence update and `seqN_valid` are visible 1 cycle after the accepted header beat.
- The drop counter increments 1 cycle after the rejected header beat.
- Reset mid-packet: the partial output packet is abandoned (`m_tvalid` goes 0). Beats after reset are parsed as a new header; the upstream is required to be reset together with this block.

## Structure
- Shared package `lego_hdr_pkg` holds:
  - header bit offsets (APP_ID_LSB=336, SEQ_LSB=344, ACK_BIT=376, SYN_BIT=377);
  - the state encoding: HDR=2'b00, FWD=2'b01, DROP=2'b10;
  - APP_ID defaults.
- These are the same offsets the ACK generator uses.
- One sub-module: `axis_reg_slice_512`, a single-stage output register carrying tdata/tkeep/tuser/tlast/tdest.

## Test plan
- Reset, then slot 0 single-beat data packets with seq 0,1,2 → three packets forwarded with `m_tdest`=0; `seq0_out`=3; `seq0_valid`=1.
- Slot 1 packet with seq=5 while expected=0 → packet dropped, no `m_` beats; `drop1_cnt`=1; `seq1_out`=0; `seq1_valid`=0.
- SYN=1, seq=FFFFFFFF on slot 1, then data packet seq=0 → both forwarded; `seq1_out`=1 (wrap).
- 3-beat packet forwarded with `m_tready` toggling 1010… → all 3 beats delivered in order and unchanged; `rx_tready` low whenever `m_tvalid` is high and `m_tready` is low.
- ACK=1 packet on slot 0, then app_id=8'h07 packet, both 2 beats → nothing forwarded; counters and expected values unchanged.
- Reset asserted during beat 2 of a 4-beat forwarded packet → next cycle `m_tvalid`=0 and expected=0; next header with seq 0 is forwarded.
